alu_seq_ctrl: RTL and testbench

- Control-side counterpart of the ALU: decodes an instruction byte into the ALU's one-hot operation flags and produces the T[7:0] timing beats that the ALU's MUL and DIV units sample.
- Drives EALU during the result beats so the ALU places its result on the shared tri-state bus.
- Sits between the instruction register / fetch logic and the ALU.
- Runs one instruction per START handshake, with fixed 8-beat timing.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_op_decode.sv | 30 +++
 rtl/alu_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control slice: opcode map, sequencer states
// and beat timing constants.
package alu_pkg;

  localparam int unsigned NBEAT    = 8;
  localparam int unsigned RES_BEAT = 6;
  localparam int unsigned NUM_OPS  = 11;

  localparam logic [3:0] OP_MOV = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h3;
  localparam logic [3:0] OP_DIV = 4'h4;
  localparam logic [3:0] OP_OR  = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: 4-bit opcode to one-hot ALU operation flags
// (bit index equals opcode value) plus an illegal-opcode indication.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0]         op,
  output logic [NUM_OPS-1:0] flags,
  output logic               illegal
);

  always_comb begin
    flags   = '0;
    illegal = 1'b0;
    case (op)
      OP_MOV:  flags[0]  = 1'b1;
      OP_ADD:  flags[1]  = 1'b1;
      OP_SUB:  flags[2]  = 1'b1;
      OP_MUL:  flags[3]  = 1'b1;
      OP_DIV:  flags[4]  = 1'b1;
      OP_OR:   flags[5]  = 1'b1;
      OP_NOT:  flags[6]  = 1'b1;
      OP_AND:  flags[7]  = 1'b1;
      OP_XOR:  flags[8]  = 1'b1;
      OP_SHL:  flags[9]  = 1'b1;
      OP_SHR:  flags[10] = 1'b1;
      default: illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU sequencer: accepts one instruction per START handshake, drives the
// one-hot T beats, the ALU operation flags and the result bus enable.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NBEAT    = alu_pkg::NBEAT,
  parameter int unsigned RES_BEAT = alu_pkg::RES_BEAT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] IR,
  output logic       BUSY,
  output logic [7:0] T,
  output logic       IMOV,
  output logic       IADD,
  output logic       ISUB,
  output logic       IMUL,
  output logic       IDIV,
  output logic       IOR,
  output logic       INOT,
  output logic       IAND,
  output logic       IXOR,
  output logic       ISHL,
  output logic       ISHR,
  output logic       EALU,
  output logic       WHI,
  output logic       DONE,
  output logic       ILL
);

  if (NBEAT != 8) begin : g_bad_nbeat
    $error("alu_seq_ctrl: NBEAT must be 8");
  end
  if (RES_BEAT + 1 >= NBEAT) begin : g_bad_res_beat
    $error("alu_seq_ctrl: RES_BEAT+1 must be a valid beat");
  end

  state_e             state;
  logic [3:0]         op_q;
  logic [NUM_OPS-1:0] flags_q;

  logic [3:0]         dec_op;
  logic [NUM_OPS-1:0] dec_flags;
  logic               dec_illegal;
  logic [7:0]         t_next;
  logic               legal;
  logic               two_result;
  logic               ir_unused;

  assign ir_unused = ^IR[3:0];

  // In IDLE the decoder looks at the incoming IR so the flags are valid in
  // the very first RUN cycle; afterwards it follows the latched opcode.
  assign dec_op = (state == IDLE) ? IR[7:4] : op_q;

  alu_op_decode u_decode (
    .op      (dec_op),
    .flags   (dec_flags),
    .illegal (dec_illegal)
  );

  assign t_next     = {T[6:0], 1'b0};
  assign legal      = |flags_q;
  assign two_result = flags_q[OP_MUL] | flags_q[OP_DIV];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      op_q    <= '0;
      flags_q <= '0;
      T       <= '0;
      BUSY    <= 1'b0;
      EALU    <= 1'b0;
      WHI     <= 1'b0;
      DONE    <= 1'b0;
      ILL     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          DONE <= 1'b0;
          ILL  <= 1'b0;
          EALU <= 1'b0;
          WHI  <= 1'b0;
          if (START) begin
            state   <= RUN;
            op_q    <= IR[7:4];
            flags_q <= dec_flags;
            T       <= 8'h01;
            BUSY    <= 1'b1;
          end
        end
        RUN: begin
          if (T[NBEAT-1]) begin
            state   <= FIN;
            flags_q <= '0;
            T       <= '0;
            BUSY    <= 1'b0;
            EALU    <= 1'b0;
            WHI     <= 1'b0;
            DONE    <= 1'b1;
            ILL     <= dec_illegal;
          end else begin
            T    <= t_next;
            EALU <= (t_next[RES_BEAT] & legal) | (t_next[RES_BEAT+1] & two_result);
            WHI  <= t_next[RES_BEAT+1] & two_result;
          end
        end
        FIN: begin
          state <= IDLE;
          DONE  <= 1'b0;
          ILL   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          flags_q <= '0;
          T       <= '0;
          BUSY    <= 1'b0;
          EALU    <= 1'b0;
          WHI     <= 1'b0;
          DONE    <= 1'b0;
          ILL     <= 1'b0;
        end
      endcase
    end
  end

  assign IMOV = flags_q[OP_MOV];
  assign IADD = flags_q[OP_ADD];
  assign ISUB = flags_q[OP_SUB];
  assign IMUL = flags_q[OP_MUL];
  assign IDIV = flags_q[OP_DIV];
  assign IOR  = flags_q[OP_OR];
  assign INOT = flags_q[OP_NOT];
  assign IAND = flags_q[OP_AND];
  assign IXOR = flags_q[OP_XOR];
  assign ISHL = flags_q[OP_SHL];
  assign ISHR = flags_q[OP_SHR];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a minimal MUL/DIV result-bus model.
module tb_alu_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic [7:0] IR;
  logic       BUSY;
  logic [7:0] T;
  logic       IMOV, IADD, ISUB, IMUL, IDIV, IOR, INOT, IAND, IXOR, ISHL, ISHR;
  logic       EALU, WHI, DONE, ILL;

  int total = 0;
  int bad   = 0;

  logic [10:0] fl;
  assign fl = {ISHR, ISHL, IXOR, IAND, INOT, IOR, IDIV, IMUL, ISUB, IADD, IMOV};

  alu_seq_ctrl #(.NBEAT(8), .RES_BEAT(6)) dut (
    .CLK(CLK), .RST(RST), .START(START), .IR(IR), .BUSY(BUSY), .T(T),
    .IMOV(IMOV), .IADD(IADD), .ISUB(ISUB), .IMUL(IMUL), .IDIV(IDIV),
    .IOR(IOR), .INOT(INOT), .IAND(IAND), .IXOR(IXOR), .ISHL(ISHL),
    .ISHR(ISHR), .EALU(EALU), .WHI(WHI), .DONE(DONE), .ILL(ILL)
  );

  always #5 CLK = ~CLK;

  // ALU stand-in: operands latched on the rising edge that ends the T[4] beat.
  logic [7:0]  A, B, a_l, b_l, bus;
  logic [15:0] prod, dvd;
  always @(posedge CLK) if (T[4]) begin a_l <= A; b_l <= B; end
  always_comb begin
    prod = 16'(a_l) * 16'(b_l);
    dvd  = {b_l, a_l};
    bus  = 8'h00;
    if (EALU && IMUL) bus = WHI ? prod[15:8] : prod[7:0];
    if (EALU && IDIV && b_l != 0) bus = WHI ? 8'(dvd % 16'(b_l)) : 8'(dvd / 16'(b_l));
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_T"}, T, 8'h00);
    chk({tag, "_flags"}, fl, 11'h000);
    chk({tag, "_ealu"}, EALU, 1'b0);
    chk({tag, "_whi"}, WHI, 1'b0);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_ill"}, ILL, 1'b0);
  endtask

  task automatic run_op(input logic [7:0] ir, input logic [7:0] exp_lo,
                        input logic [7:0] exp_hi, input bit bus_on);
    logic [3:0]  op;
    bit          legal, two;
    logic [10:0] exp_fl;
    op     = ir[7:4];
    legal  = (op <= 4'hA);
    two    = (op == 4'h3) || (op == 4'h4);
    exp_fl = legal ? (11'h001 << op) : 11'h000;
    IR = ir; START = 1'b1;
    tick;
    START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("beat_T", T, 8'h01 << i);
      chk("beat_flags", fl, exp_fl);
      chk("beat_busy", BUSY, 1'b1);
      chk("beat_done", DONE, 1'b0);
      chk("beat_ealu", EALU, legal && (i == 6 || (i == 7 && two)));
      chk("beat_whi", WHI, two && i == 7);
      if (bus_on && i == 6) chk("bus_lo", bus, exp_lo);
      if (bus_on && i == 7) chk("bus_hi", bus, exp_hi);
      IR = ~IR;
      tick;
    end
    chk("fin_T", T, 8'h00);
    chk("fin_flags", fl, 11'h000);
    chk("fin_done", DONE, 1'b1);
    chk("fin_ill", ILL, !legal);
    chk("fin_busy", BUSY, 1'b0);
    chk("fin_ealu", EALU, 1'b0);
    tick;
    chk_quiet("idle");
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; IR = 8'h00; A = 8'h00; B = 8'h00;
    #1;
    chk_quiet("reset");
    tick; tick;
    RST = 1'b0;
    tick;

    // Reset in the T=8'h08 cycle aborts without DONE
    IR = 8'h10; START = 1'b1;
    tick;
    START = 1'b0;
    tick; tick; tick;
    chk("abort_pre_T", T, 8'h08);
    chk("abort_pre_iadd", IADD, 1'b1);
    RST = 1'b1;
    #1;
    chk_quiet("abort");
    tick;
    RST = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("abort_no_done", DONE, 1'b0);
      tick;
    end

    run_op(8'h10, 8'h00, 8'h00, 1'b0);
    A = 8'd200; B = 8'd3;
    run_op(8'h30, 8'h58, 8'h02, 1'b1);       // 200*3 = 600 = 16'h0258
    A = 8'h2C; B = 8'h07;
    run_op(8'h40, 8'h06, 8'h02, 1'b1);       // 16'h072C = 1836 = 7*262 + 2; 262 = 9'h106
    run_op(8'hF3, 8'h00, 8'h00, 1'b0);
    run_op(8'hB0, 8'h00, 8'h00, 1'b0);
    run_op(8'h0F, 8'h00, 8'h00, 1'b0);
    run_op(8'hA5, 8'h00, 8'h00, 1'b0);

    // START held high: accepted every 10 cycles, IR changes mid-run ignored
    IR = 8'h60; START = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      int ph;
      tick;
      ph = (c - 1) % 10;
      chk("held_T", T, (ph < 8) ? (8'h01 << ph) : 8'h00);
      chk("held_busy", BUSY, ph < 8);
      chk("held_done", DONE, ph == 8);
      chk("held_inot", INOT, ph < 8);
      chk("held_iadd", IADD, 1'b0);
      if (c == 3) IR = 8'h10;
      if (c == 9) IR = 8'h60;
    end
    START = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
